// File: rtl/led_frame_buffer.sv
// Double-buffered GRB frame store: host fills the back bank, encoder reads the front bank.
// Optional per-channel brightness scaling on the read path when BRIGHTNESS_SCALE_EN is defined.
module led_frame_buffer #(
  parameter int LED_COUNT     = 60,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clock_12mhz,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [23:0]              write_data,
  output logic                     write_ready,
  input  logic                     frame_commit,
  output logic                     write_dropped,
  input  logic                     frame_sync,
  input  logic                     led_request,
  input  logic [ADDRESS_WIDTH-1:0] led_index,
  input  logic [7:0]               brightness,
  output logic [23:0]              parallel_data_out,
  output logic                     data_valid,
  output logic                     frame_swapped
);

  localparam int STAGES = 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(LED_COUNT - 1);

  typedef enum logic {FILLING, PENDING} state_t;

  state_t state, state_nxt;
  logic   front;
  logic   swap;

  logic [23:0] mem [2][LED_COUNT];

  logic [STAGES:0]          vld_pipe;
  logic [ADDRESS_WIDTH-1:0] rd_idx;
  logic                     rd_bank;
  logic [23:0]              rd_word;
  logic [23:0]              shaped;

  // Bank FSM: a commit arms the swap, which only lands during blanking.
  always_comb begin
    state_nxt   = state;
    swap        = 1'b0;
    write_ready = 1'b0;
    case (state)
      FILLING: begin
        write_ready = 1'b1;
        if (frame_commit) state_nxt = PENDING;
      end
      PENDING: begin
        if (frame_sync) begin
          swap      = 1'b1;
          state_nxt = FILLING;
        end
      end
      default: state_nxt = FILLING;
    endcase
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state         <= FILLING;
      front         <= 1'b0;
      frame_swapped <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      state         <= state_nxt;
      front         <= front ^ swap;
      frame_swapped <= swap;
      if (write_enable && !write_ready) write_dropped <= 1'b1;
    end
  end

  // Writes only ever target the back bank; a swap never coincides with a write.
  always_ff @(posedge clock_12mhz) begin
    if (write_enable && write_ready && (write_address <= LAST_INDEX))
      mem[~front][write_address] <= write_data;
  end

  always_comb begin
    rd_word = '0;
    if (rd_idx <= LAST_INDEX) rd_word = mem[rd_bank][rd_idx];
  end

`ifdef BRIGHTNESS_SCALE_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  always_comb
    shaped = {scale_ch(rd_word[23:16], brightness),
              scale_ch(rd_word[15:8],  brightness),
              scale_ch(rd_word[7:0],   brightness)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign shaped = rd_word;
`endif

  // Stage 1 captures front with the index, so a request on a swap edge reads the old frame.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      vld_pipe          <= '0;
      rd_idx            <= '0;
      rd_bank           <= 1'b0;
      parallel_data_out <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], led_request};
      if (led_request) begin
        rd_idx  <= led_index;
        rd_bank <= front;
      end
      if (vld_pipe[STAGES-1]) parallel_data_out <= shaped;
    end
  end

  assign data_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomized scoreboard bench for led_frame_buffer against a bank-level reference model.
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [5:0]  write_address = '0;
  logic [23:0] write_data = '0;
  logic        frame_commit = 1'b0;
  logic        frame_sync = 1'b0;
  logic        led_request = 1'b0;
  logic [5:0]  led_index = '0;
  logic [7:0]  brightness = 8'd255;
  logic        write_ready, write_dropped, data_valid, frame_swapped;
  logic [23:0] parallel_data_out;

  led_frame_buffer #(.LED_COUNT(60), .ADDRESS_WIDTH(6)) dut (
    .clock_12mhz(clk), .reset(reset),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .write_ready(write_ready), .frame_commit(frame_commit), .write_dropped(write_dropped),
    .frame_sync(frame_sync), .led_request(led_request), .led_index(led_index),
    .brightness(brightness), .parallel_data_out(parallel_data_out),
    .data_valid(data_valid), .frame_swapped(frame_swapped)
  );

  always #5 clk = ~clk;

  typedef struct {logic [23:0] d; bit chk; int due;} exp_t;
  exp_t q[$];

  logic [23:0] bank_d [2][64];
  bit          known  [2][64];
  bit          m_front, m_pending, m_dropped, m_swapped;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
`ifdef BRIGHTNESS_SCALE_EN
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) * (int'(b) + 1)) / 256);
    return r;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: advance the reference model on the edge, then check control outputs.
  task automatic step();
    logic [23:0] raw;
    bit ok;
    @(posedge clk);
    foreach (q[i]) if (q[i].due == cyc + 1) q[i].d = scale_word(q[i].d, brightness);
    if (led_request) begin
      raw = '0;
      ok  = 1'b1;
      if (led_index < 60) begin
        raw = bank_d[m_front][led_index];
        ok  = known[m_front][led_index];
      end
      q.push_back('{d: raw, chk: ok, due: cyc + 2});
    end
    if (write_enable && m_pending) m_dropped = 1'b1;
    if (write_enable && !m_pending && write_address < 60) begin
      bank_d[!m_front][write_address] = write_data;
      known[!m_front][write_address]  = 1'b1;
    end
    m_swapped = 1'b0;
    if (m_pending && frame_sync) begin
      m_front   = !m_front;
      m_pending = 1'b0;
      m_swapped = 1'b1;
    end else if (!m_pending && frame_commit) begin
      m_pending = 1'b1;
    end
    cyc++;
    @(negedge clk);
    chk("write_ready", write_ready, !m_pending);
    chk("frame_swapped", frame_swapped, m_swapped);
    chk("write_dropped", write_dropped, m_dropped);
  endtask

  task automatic drive(input bit we, input logic [5:0] wa, input logic [23:0] wd,
                       input bit cm, input bit sy, input bit rq, input logic [5:0] ix);
    write_enable = we; write_address = wa; write_data = wd;
    frame_commit = cm; frame_sync = sy; led_request = rq; led_index = ix;
    step();
  endtask

  task automatic idle(input int n, input bit sy);
    repeat (n) drive(0, 0, 0, 0, sy, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_front = 0; m_pending = 0; m_dropped = 0; m_swapped = 0;
    foreach (known[b, i]) known[b][i] = 1'b0;
  endtask

  // Monitor: every data_valid pops the oldest expectation and checks value and latency.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL spurious_valid: got data_valid=1 data=%h expected no output", parallel_data_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("read_latency", cyc, e.due);
          if (e.chk) chk("read_data", parallel_data_out, e.d);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        nvec++; nerr++;
        $display("FAIL missing_valid: got data_valid=0 expected 1 (due cycle %0d)", q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_data_out", parallel_data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_write_ready", write_ready, 1);
    chk("rst_write_dropped", write_dropped, 0);
    chk("rst_frame_swapped", frame_swapped, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fill back bank, 808080 at index 3, commit during blanking, read it back.
    for (int a = 0; a < 60; a++) drive(1, 6'(a), 24'($urandom), 0, 0, 0, 0);
    drive(1, 3, 24'h808080, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 3);
    idle(2, 0);

    // Fill the other bank, commit outside blanking, attempt a dropped write.
    for (int a = 0; a < 60; a++) drive(1, 6'(a), 24'($urandom), 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(4, 0);
    drive(1, 0, 24'hABCDEF, 0, 0, 0, 0);
    idle(5, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Sweep every index back to back, plus out-of-range ones.
    for (int i = 0; i < 64; i++) drive(0, 0, 0, 0, 0, 1, 6'(i));
    idle(3, 0);

    // Request on the swap edge sees the old front; the next one sees the new front.
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 5);
    drive(0, 0, 0, 0, 0, 1, 5);
    idle(3, 0);

    // Brightness path (identity when scaling is compiled out).
    drive(1, 7, 24'hFF4002, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    brightness = 8'd127;
    drive(0, 0, 0, 0, 0, 1, 7);
    idle(3, 0);
    brightness = 8'd0;
    drive(0, 0, 0, 0, 0, 1, 7);
    idle(3, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      brightness = 8'($urandom);
      drive(bit'($urandom % 2), 6'($urandom_range(0, 63)), 24'($urandom),
            ($urandom % 16) == 0, ($urandom % 4) == 0,
            bit'($urandom % 2), 6'($urandom_range(0, 63)));
    end
    idle(3, 0);

    // Reset with a read in flight, a swap pending and a dropped write recorded.
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 24'h123456, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 1, 4);
    #2 reset = 1'b1;
    write_enable = 0; frame_commit = 0; frame_sync = 0; led_request = 0;
    #1;
    chk("midrst_data_valid", data_valid, 0);
    chk("midrst_data_out", parallel_data_out, 0);
    chk("midrst_write_ready", write_ready, 1);
    chk("midrst_write_dropped", write_dropped, 0);
    chk("midrst_frame_swapped", frame_swapped, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4, 1);

    // After reset: fresh back bank, swap, read back.
    for (int a = 0; a < 60; a++) drive(1, 6'(a), 24'($urandom), 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, 6'($urandom_range(0, 63)));
    idle(4, 0);
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered pixel store between the host write interface and the `encoder_xx6812` strip encoder. The host fills a back bank of `LED_COUNT` 24-bit GRB words while the front bank is read out LED by LED. On each request the block delivers the addressed word on `parallel_data_out` with a fixed 2-cycle latency. A host commit swaps the banks, but only at the next frame-blanking boundary, so the strip never shows a mixed frame.

## Interface
- `LED_COUNT`, 60: LEDs per strip; valid indices are 0..`LED_COUNT-1`.
- `ADDRESS_WIDTH`, 6: width of index and address ports; must satisfy 2^`ADDRESS_WIDTH` >= `LED_COUNT`.

- `clock_12mhz`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high.
- `write_enable`  in  1  host write strobe, one word per cycle.
- `write_address`  in  `ADDRESS_WIDTH`  back-bank word index.
- `write_data`  in  24  GRB word, G in [23:16].
- `write_ready`  out  1  high when writes are accepted.
- `frame_commit`  in  1  one-cycle pulse: the back bank is complete.
- `write_dropped`  out  1  sticky; a write was rejected.
- `frame_sync`  in  1  high during inter-frame blanking (`framerate`).
- `led_request`  in  1  one-cycle pulse: fetch `led_index`.
- `led_index`  in  `ADDRESS_WIDTH`  front-bank word index.
- `brightness`  in  8  global scale; used only with `BRIGHTNESS_SCALE_EN`.
- `parallel_data_out`  out  24  fetched word, to the encoder.
- `data_valid`  out  1  one-cycle pulse qualifying `parallel_data_out`.
- `frame_swapped`  out  1  one-cycle pulse; the banks have swapped.

## Operation
- Storage: two banks of `LED_COUNT` x 24 bits. The `front` bit selects the read bank; `~front` is the write bank.
- Write path: when `write_enable && write_ready && write_address < LED_COUNT`, the word is stored in the back bank at the next edge.
  - Writes with `write_ready` low set `write_dropped` and have no other effect.
  - Writes to an out-of-range address are ignored silently; `write_dropped` is not set.
- Bank FSM has two states:
  - FILLING: `write_ready` = 1. On `frame_commit` the FSM goes to PENDING.
  - PENDING: `write_ready` = 0. While `frame_sync` is high, at the next edge: toggle `front`, pulse `frame_swapped`, return to FILLING.
  - `frame_commit` in PENDING is ignored.
  - If `frame_commit` arrives while `frame_sync` is already high, the swap occurs on the following cycle.
- No copy on swap: the new back bank holds the frame from two commits ago.
- Read pipeline:
  - Stage 1 registers `led_index` and the current `front` bit on `led_request`.
  - Stage 2 reads the RAM.
  - The output register then loads `parallel_data_out` and pulses `data_valid`.
  - An out-of-range `led_index` yields 24'h000000, with `data_valid` still pulsed.
- Back-to-back requests on consecutive cycles are supported, at one result per cycle.
- A request in the same cycle as a swap edge reads the bank that was front before the edge.
- A write and a swap in the same cycle cannot occur, because `write_ready` = 0 in PENDING.

## Timing
- Reset values: `parallel_data_out` = 0, `data_valid` = 0, `write_ready` = 1, `write_dropped` = 0, `frame_swapped` = 0, `front` = 0, FSM = FILLING, pipeline empty.
- RAM contents are undefined after reset.
- Read latency: `led_request` in cycle N gives `data_valid` in cycle N+2. This is independent of configuration.
- Swap latency: 1 cycle after `frame_commit` at the earliest. `write_ready` rises in the same cycle as `frame_swapped`.
- Reset asserted mid-frame aborts the pipeline and any pending swap: `data_valid` drops immediately and no `frame_swapped` is emitted.

## Configuration
- `BRIGHTNESS_SCALE_EN` defined:
  - The output stage scales each 8-bit channel independently: out = (c * (`brightness` + 1)) >> 8, with a 16-bit intermediate, truncated.
  - `brightness` = 255 is identity; `brightness` = 0 maps 255 to 0.
  - Latency is unchanged at 2 cycles.
- `BRIGHTNESS_SCALE_EN` undefined: the word passes unmodified and `brightness` is ignored.

## Test plan
- Reset, write 24'h808080 to address 3, commit, hold `frame_sync` high, request index 3 -> `frame_swapped` pulses 1 cycle after commit; `data_valid` and 24'h808080 appear 2 cycles after the request.
- Commit with `frame_sync` low for 10 cycles, then write address 0 -> `write_ready` = 0, `write_dropped` = 1, no swap until `frame_sync` rises, back-bank word unchanged.
- Request indices 0..59 on consecutive cycles -> 60 consecutive `data_valid` pulses in index order; request index 60 -> 24'h000000.
- Request in the same cycle as the swap edge -> returns old-front data; the next request returns new-front data.
- With `BRIGHTNESS_SCALE_EN` and `brightness` = 127, stored 24'hFF4002 -> output 24'h7F2001.
- Assert `reset` while `data_valid` is in flight and a swap is pending -> all outputs at reset values, `front` = 0, no `frame_swapped` pulse.
